spi_reg_bank_ctrl: RTL and testbench
====================================

Name: spi_reg_bank_ctrl

Overview:
- Command decoder and register bank behind the SPI receive front end.
- Consumes the received byte stream: byte pulses, byte data and the transaction-active flag.
- Decodes a command byte followed by data bytes, and writes the data into a shadow register bank.
- When the transaction closes, copies the whole shadow bank to the active bank in one cycle, so the tone generator channels see all parameters of a transaction change together, glitch-free.

Parameters:
- NUM_REGS, 16, number of 8-bit registers; power of two, 2..16.
- ADDR_W, 4, register address width; log2(NUM_REGS) ≤ ADDR_W ≤ 4.

Ports:
- clk_in  input  1  system clock, same domain as the SPI receive front end.
- reset_in  input  1  reset; asynchronous, active-high.
- rx_data_in  input  8  received byte; valid only while rx_valid_in=1.
- rx_valid_in  input  1  one-cycle pulse per received byte.
- transaction_valid_in  input  1  high while chip select is active (already synchronized).
- regs_out  output  NUM_REGS*8  active register bank, flattened; register n is at [8n+7:8n].
- commit_out  output  1  one-cycle pulse when the active bank is updated.
- busy_out  output  1  high while not in IDLE.
- err_out  output  1  sticky error flag; cleared at the next transaction start.

Behaviour:
- Async reset: shadow and active banks = 0x00, state = IDLE, commit_out=0, busy_out=0, err_out=0, internal addr=0, dirty=0.
- Command byte format:
  - bit7 W: 1 = write; 0 = no-op, transaction ignored.
  - bit6 INC: 1 = auto-increment address after each data byte.
  - bits5:4 reserved, ignored.
  - bits3:0 start address.
- States:
  - IDLE: on transaction_valid_in=1, go to CMD and clear err_out. Bytes arriving in IDLE are dropped.
  - CMD: on rx_valid_in:
    - if W=0, go to SKIP;
    - else if address ≥ NUM_REGS, go to SKIP and set err_out;
    - else latch addr and INC, go to DATA.
  - DATA: on rx_valid_in, shadow[addr] ← rx_data_in and set dirty.
    - If INC=1: addr ← addr+1, wrapping NUM_REGS-1 → 0.
    - If INC=0: addr holds, so later bytes overwrite the same register.
  - SKIP: consume bytes without effect.
- Transaction end: transaction_valid_in=0 observed in CMD, DATA or SKIP.
  - A byte pulse in that same cycle is still processed by the current state (the final byte is never lost).
  - Next state is COMMIT.
- COMMIT, one cycle:
  - If dirty=1: active bank ← shadow bank, commit_out=1 in this cycle, dirty cleared.
  - If dirty=0: no copy, commit_out stays 0.
  - Always returns to IDLE.
  - transaction_valid_in=1 during COMMIT is not lost: the next IDLE cycle sees it and starts a new transaction.
- Latency: regs_out reflects a transaction's last data byte 2 cycles after the cycle transaction_valid_in falls (1 cycle to COMMIT, copy registered at the end of COMMIT). commit_out is high during the COMMIT cycle.
- Shadow bank keeps its contents between transactions. A partial write (for example, one register only) commits the unchanged registers as they were.
- Command with no data bytes: dirty=0, no commit.
- Error transaction: no shadow writes.
- Reset mid-transaction: everything returns to reset values immediately and the partial shadow data is discarded. A byte stream already in progress is ignored until transaction_valid_in goes 0 and then 1 again. Rule: leave reset into a state that waits for transaction_valid_in=0 first.
- regs_out is driven from flops only, never from the shadow bank.
- busy_out = (state != IDLE).

Test Plan:
- Single write: CS active, bytes 0x83, 0x5A, CS inactive → commit_out pulses once; reg3=0x5A; all other registers 0x00; regs_out unchanged before commit.
- Burst with increment: 0xCE, 0x11, 0x22, 0x33 (NUM_REGS=16) → reg14=0x11, reg15=0x22, reg0=0x33 (wrap); one commit pulse.
- No increment: 0x82, 0x01, 0x02, 0x03 → reg2=0x03 only; other registers unchanged.
- Error / no-op cases, each → err_out=1 or not as stated, no commit, regs_out unchanged:
  - NUM_REGS=8, command 0x89 → err_out=1.
  - Command 0x05 → err_out=0.
  - A following valid transaction clears err_out.
- Final byte with rx_valid_in in the same cycle transaction_valid_in falls (0x80, 0x77) → reg0=0x77, commit_out asserted exactly 1 cycle later.
- Async reset asserted between data bytes of 0xC0, 0xAA, [reset], 0xBB, then CS inactive/active and 0x81, 0x44 → bank all zero except reg1=0x44; 0xBB never written.

Source files
------------

// File: rtl/spi_reg_bank_ctrl.sv
// Command decoder and double-buffered register bank fed by the SPI byte receiver.
// Data bytes land in a shadow bank; the whole shadow bank is copied to the
// active bank in a single cycle when the transaction closes.
module spi_reg_bank_ctrl #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [7:0]            rx_data_in,
    input  logic                  rx_valid_in,
    input  logic                  transaction_valid_in,
    output logic [NUM_REGS*8-1:0] regs_out,
    output logic                  commit_out,
    output logic                  busy_out,
    output logic                  err_out
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_SKIP,
        ST_COMMIT
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic             inc_q, inc_d;
    logic             dirty_q, dirty_d;
    logic             armed_q, armed_d;
    logic             err_q, err_d;
    logic             commit_q, commit_d;
    logic             busy_q, busy_d;
    logic [7:0]       shadow_q [NUM_REGS];
    logic [7:0]       shadow_d [NUM_REGS];
    logic [7:0]       active_q [NUM_REGS];
    logic [7:0]       active_d [NUM_REGS];

    logic [ADDR_W-1:0] cmd_addr;
    assign cmd_addr = rx_data_in[ADDR_W-1:0];

    // Next-state, bank update and registered output logic
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        inc_d    = inc_q;
        dirty_d  = dirty_q;
        err_d    = err_q;
        shadow_d = shadow_q;
        active_d = active_q;
        // A start is only honoured after chip select has been seen low once,
        // so a stream cut by reset is ignored until it restarts cleanly.
        armed_d  = armed_q | ~transaction_valid_in;

        case (state_q)
            ST_IDLE: begin
                if (armed_q && transaction_valid_in) begin
                    state_d = ST_CMD;
                    err_d   = 1'b0;
                end
            end
            ST_CMD: begin
                if (rx_valid_in) begin
                    if (!rx_data_in[7]) begin
                        state_d = ST_SKIP;
                    end else if (32'(cmd_addr) >= NUM_REGS) begin
                        state_d = ST_SKIP;
                        err_d   = 1'b1;
                    end else begin
                        addr_d  = cmd_addr[IDX_W-1:0];
                        inc_d   = rx_data_in[6];
                        state_d = ST_DATA;
                    end
                end
                if (!transaction_valid_in) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_DATA: begin
                if (rx_valid_in) begin
                    shadow_d[addr_q] = rx_data_in;
                    dirty_d          = 1'b1;
                    if (inc_q) begin
                        addr_d = (addr_q == IDX_W'(NUM_REGS - 1)) ? '0 : addr_q + IDX_W'(1);
                    end
                end
                if (!transaction_valid_in) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_SKIP: begin
                if (!transaction_valid_in) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (dirty_q) begin
                    active_d = shadow_q;
                end
                dirty_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        commit_d = (state_d == ST_COMMIT) && dirty_d;
        busy_d   = (state_d != ST_IDLE);
    end

    // State, bank and output registers
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            inc_q    <= 1'b0;
            dirty_q  <= 1'b0;
            armed_q  <= 1'b0;
            err_q    <= 1'b0;
            commit_q <= 1'b0;
            busy_q   <= 1'b0;
            shadow_q <= '{default: 8'h00};
            active_q <= '{default: 8'h00};
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            inc_q    <= inc_d;
            dirty_q  <= dirty_d;
            armed_q  <= armed_d;
            err_q    <= err_d;
            commit_q <= commit_d;
            busy_q   <= busy_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // Flatten the active bank onto the output bus
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign regs_out[g*8 +: 8] = active_q[g];
    end

    assign commit_out = commit_q;
    assign busy_out   = busy_q;
    assign err_out    = err_q;

endmodule

// File: tb/tb_spi_reg_bank_ctrl.sv
// Bench for spi_reg_bank_ctrl: a 16-register and an 8-register instance share
// stimulus and are checked against a transaction-level model of the bank.
module tb_spi_reg_bank_ctrl;

    logic         clk_in = 1'b0;
    logic         reset_in;
    logic [7:0]   rx_data_in;
    logic         rx_valid_in;
    logic         transaction_valid_in;
    logic [127:0] regs16;
    logic [63:0]  regs8;
    logic         commit16, commit8, busy16, busy8, err16, err8;
    logic [1:0]   commit_w, busy_w, err_w;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    spi_reg_bank_ctrl #(.NUM_REGS(16), .ADDR_W(4)) u_dut16 (
        .clk_in(clk_in), .reset_in(reset_in), .rx_data_in(rx_data_in),
        .rx_valid_in(rx_valid_in), .transaction_valid_in(transaction_valid_in),
        .regs_out(regs16), .commit_out(commit16), .busy_out(busy16), .err_out(err16));

    spi_reg_bank_ctrl #(.NUM_REGS(8), .ADDR_W(4)) u_dut8 (
        .clk_in(clk_in), .reset_in(reset_in), .rx_data_in(rx_data_in),
        .rx_valid_in(rx_valid_in), .transaction_valid_in(transaction_valid_in),
        .regs_out(regs8), .commit_out(commit8), .busy_out(busy8), .err_out(err8));

    assign commit_w = {commit8, commit16};
    assign busy_w   = {busy8, busy16};
    assign err_w    = {err8, err16};

    // Reference model: register contents per instance (index 0 = 16 regs, 1 = 8 regs)
    logic [7:0] m_shadow [2][16];
    logic [7:0] m_active [2][16];
    logic       m_err [2];
    int         ncommit [2];
    logic [7:0] txn_q [$];

    // Commit pulse counter per instance
    always @(negedge clk_in) begin
        if (commit16) ncommit[0]++;
        if (commit8)  ncommit[1]++;
    end

    function automatic int nregs(input int k);
        return (k == 0) ? 16 : 8;
    endfunction

    function automatic logic [127:0] exp_flat(input int k);
        logic [127:0] v = '0;
        for (int i = 0; i < nregs(k); i++) v[i*8 +: 8] = m_active[k][i];
        return v;
    endfunction

    function automatic logic [127:0] act_flat(input int k);
        return (k == 0) ? regs16 : {64'h0, regs8};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 1'b0;
            for (int i = 0; i < 16; i++) begin
                m_shadow[k][i] = 8'h00;
                m_active[k][i] = 8'h00;
            end
        end
    endtask

    // Apply txn_q (command then data) to the model; returns which instances commit
    task automatic model_txn(output logic [1:0] wrote);
        for (int k = 0; k < 2; k++) begin
            int n;
            int a;
            n = nregs(k);
            wrote[k] = 1'b0;
            m_err[k] = 1'b0;
            if (txn_q.size() > 0 && txn_q[0][7]) begin
                a = int'(txn_q[0][3:0]);
                if (a >= n) begin
                    m_err[k] = 1'b1;
                end else begin
                    for (int i = 1; i < txn_q.size(); i++) begin
                        m_shadow[k][a] = txn_q[i];
                        wrote[k] = 1'b1;
                        if (txn_q[0][6]) a = (a + 1) % n;
                    end
                end
            end
            if (wrote[k]) begin
                for (int i = 0; i < 16; i++) m_active[k][i] = m_shadow[k][i];
            end
        end
    endtask

    // Drive one chip-select window carrying txn_q and check the commit behaviour
    task automatic send_txn(input bit drop_with_last, input bit b2b);
        logic [1:0] exp_commit;
        int         c0 [2];
        bit         dropped;
        dropped = drop_with_last && (txn_q.size() > 0);
        @(negedge clk_in);
        transaction_valid_in = 1'b1;
        @(negedge clk_in);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (busy_w[k] !== 1'b1) begin
                bad++; $display("FAIL start_busy k=%0d got=%b exp=1", k, busy_w[k]);
            end
            total++;
            if (err_w[k] !== 1'b0) begin
                bad++; $display("FAIL start_err_clear k=%0d got=%b exp=0", k, err_w[k]);
            end
            c0[k] = ncommit[k];
        end
        for (int i = 0; i < txn_q.size(); i++) begin
            bit last;
            last = (i == txn_q.size() - 1);
            rx_valid_in = 1'b1;
            rx_data_in  = txn_q[i];
            if (dropped && last) transaction_valid_in = 1'b0;
            @(negedge clk_in);
            rx_valid_in = 1'b0;
            rx_data_in  = 8'($urandom);
            if (!(dropped && last)) repeat ($urandom_range(0, 2)) @(negedge clk_in);
        end
        if (!dropped) begin
            transaction_valid_in = 1'b0;
            @(negedge clk_in);
        end
        // COMMIT cycle: bank not yet updated, pulse expected only if data was written
        for (int k = 0; k < 2; k++) begin
            total++;
            if (act_flat(k) !== exp_flat(k)) begin
                bad++; $display("FAIL pre_commit_regs k=%0d got=%h exp=%h", k, act_flat(k), exp_flat(k));
            end
        end
        model_txn(exp_commit);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (commit_w[k] !== exp_commit[k]) begin
                bad++; $display("FAIL commit_pulse k=%0d got=%b exp=%b", k, commit_w[k], exp_commit[k]);
            end
            total++;
            if (busy_w[k] !== 1'b1) begin
                bad++; $display("FAIL commit_busy k=%0d got=%b exp=1", k, busy_w[k]);
            end
        end
        if (b2b) transaction_valid_in = 1'b1;
        @(negedge clk_in);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (commit_w[k] !== 1'b0) begin
                bad++; $display("FAIL commit_width k=%0d got=%b exp=0", k, commit_w[k]);
            end
            total++;
            if (busy_w[k] !== 1'b0) begin
                bad++; $display("FAIL idle_busy k=%0d got=%b exp=0", k, busy_w[k]);
            end
            total++;
            if (act_flat(k) !== exp_flat(k)) begin
                bad++; $display("FAIL post_commit_regs k=%0d got=%h exp=%h", k, act_flat(k), exp_flat(k));
            end
            total++;
            if (err_w[k] !== m_err[k]) begin
                bad++; $display("FAIL err_flag k=%0d got=%b exp=%b", k, err_w[k], m_err[k]);
            end
            total++;
            if ((ncommit[k] - c0[k]) !== int'(exp_commit[k])) begin
                bad++; $display("FAIL commit_count k=%0d got=%0d exp=%0d", k, ncommit[k] - c0[k], exp_commit[k]);
            end
        end
    endtask

    task automatic test_reset();
        reset_in             = 1'b1;
        transaction_valid_in = 1'b0;
        rx_valid_in          = 1'b0;
        rx_data_in           = 8'h00;
        model_reset();
        repeat (3) @(negedge clk_in);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (act_flat(k) !== 128'h0) begin
                bad++; $display("FAIL reset_regs k=%0d got=%h exp=0", k, act_flat(k));
            end
            total++;
            if ({commit_w[k], busy_w[k], err_w[k]} !== 3'b000) begin
                bad++; $display("FAIL reset_flags k=%0d got=%b exp=000", k, {commit_w[k], busy_w[k], err_w[k]});
            end
        end
        reset_in = 1'b0;
    endtask

    task automatic test_single_write();
        txn_q = '{8'h83, 8'h5A};
        send_txn(1'b0, 1'b0);
    endtask

    task automatic test_burst_inc();
        txn_q = '{8'hCE, 8'h11, 8'h22, 8'h33};
        send_txn(1'b0, 1'b0);
    endtask

    task automatic test_no_inc();
        txn_q = '{8'h82, 8'h01, 8'h02, 8'h03};
        send_txn(1'b0, 1'b0);
    endtask

    task automatic test_error();
        txn_q = '{8'h89};
        send_txn(1'b0, 1'b0);
        repeat (3) @(negedge clk_in);
        total++;
        if (err_w[1] !== 1'b1) begin
            bad++; $display("FAIL err_sticky got=%b exp=1", err_w[1]);
        end
        txn_q = '{8'h05, 8'h12, 8'h34};
        send_txn(1'b0, 1'b0);
        txn_q = '{8'h81, 8'h99};
        send_txn(1'b0, 1'b0);
    endtask

    task automatic test_final_byte();
        txn_q = '{8'h80, 8'h77};
        send_txn(1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        txn_q = '{8'hC4, 8'hA1, 8'hA2};
        send_txn(1'b0, 1'b1);
        txn_q = '{8'h85, 8'hB3};
        send_txn(1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic [7:0] c;
            int         nd;
            c = 8'($urandom);
            if ($urandom_range(0, 4) != 0) c[7] = 1'b1;
            nd = $urandom_range(0, 5);
            txn_q = '{c};
            for (int i = 0; i < nd; i++) txn_q.push_back(8'($urandom));
            send_txn(1'($urandom_range(0, 1)), (t != 39) && ($urandom_range(0, 2) == 0));
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] seq [3] = '{8'hC0, 8'hAA, 8'hBB};
        @(negedge clk_in);
        transaction_valid_in = 1'b1;
        @(negedge clk_in);
        for (int i = 0; i < 2; i++) begin
            rx_valid_in = 1'b1;
            rx_data_in  = seq[i];
            @(negedge clk_in);
            rx_valid_in = 1'b0;
        end
        #2 reset_in = 1'b1;
        model_reset();
        @(negedge clk_in);
        reset_in = 1'b0;
        rx_valid_in = 1'b1;
        rx_data_in  = seq[2];
        @(negedge clk_in);
        rx_valid_in = 1'b0;
        repeat (2) @(negedge clk_in);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (busy_w[k] !== 1'b0) begin
                bad++; $display("FAIL reset_mid_busy k=%0d got=%b exp=0", k, busy_w[k]);
            end
            total++;
            if (act_flat(k) !== 128'h0) begin
                bad++; $display("FAIL reset_mid_regs k=%0d got=%h exp=0", k, act_flat(k));
            end
        end
        transaction_valid_in = 1'b0;
        repeat (2) @(negedge clk_in);
        txn_q = '{8'h81, 8'h44};
        send_txn(1'b0, 1'b0);
    endtask

    initial begin
        ncommit[0] = 0;
        ncommit[1] = 0;
        test_reset();
        test_single_write();
        test_burst_inc();
        test_no_inc();
        test_error();
        test_final_byte();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
